// File: rtl/fmul_pipe.sv
// rtl/fmul_pipe.sv - pipelined NE/NF floating-point multiplier with valid/ready streaming
module fmul_pipe #(
    parameter int NE   = 5,
    parameter int NF   = 10,
    parameter int TAGW = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NE+NF:0]    x,
    input  logic [NE+NF:0]    y,
    input  logic              negp,
    input  logic [1:0]        roundmode,
    input  logic [TAGW-1:0]   in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NE+NF:0]    product,
    output logic [3:0]        flags,
    output logic [TAGW-1:0]   out_tag
);
    localparam int W  = NE + NF + 1;
    localparam int EW = NE + 2;
    localparam int MW = 2 * NF + 2;
    localparam logic [EW-1:0]        BIAS = EW'((1 << (NE - 1)) - 1);
    localparam logic signed [EW-1:0] EMAX = EW'((1 << NE) - 1);
    localparam logic [W-1:0]         QNAN = {1'b0, {NE{1'b1}}, 1'b1, {(NF-1){1'b0}}};
    localparam logic [1:0] MODE_RZ = 2'b00, MODE_RNE = 2'b01, MODE_RM = 2'b10, MODE_RP = 2'b11;

    logic en;
    assign en       = ~(out_valid & ~out_ready);
    assign in_ready = en;

    // Operands are registered on accept; S1 works from this register.
    logic            r0_valid, r0_negp;
    logic [W-1:0]    r0_x, r0_y;
    logic [1:0]      r0_rm;
    logic [TAGW-1:0] r0_tag;

    always_ff @(posedge clk) begin
        if (reset) begin
            r0_valid <= 1'b0;
        end else if (en) begin
            r0_valid <= in_valid;
            r0_x     <= x;
            r0_y     <= y;
            r0_negp  <= negp;
            r0_rm    <= roundmode;
            r0_tag   <= in_tag;
        end
    end

    logic [NE-1:0] ex, ey;
    logic [NF-1:0] fx, fy;
    logic          sgn1, x_nan, y_nan, x_inf, y_inf, x_zero, y_zero;
    logic [MW-1:0] mul1;
    logic [EW-1:0] esum1;
    logic          spec1, inv1;
    logic [W-1:0]  sval1;

    assign ex     = r0_x[W-2:NF];
    assign ey     = r0_y[W-2:NF];
    assign fx     = r0_x[NF-1:0];
    assign fy     = r0_y[NF-1:0];
    assign sgn1   = r0_x[W-1] ^ r0_y[W-1] ^ r0_negp;
    assign x_nan  = (&ex) & (|fx);
    assign y_nan  = (&ey) & (|fy);
    assign x_inf  = (&ex) & ~(|fx);
    assign y_inf  = (&ey) & ~(|fy);
    assign x_zero = ~(|ex);
    assign y_zero = ~(|ey);
    assign mul1   = {{(NF+1){1'b0}}, 1'b1, fx} * {{(NF+1){1'b0}}, 1'b1, fy};
    assign esum1  = {2'b00, ex} + {2'b00, ey} - BIAS;

    // Subnormal operands fall into the zero class (flush-to-zero).
    always_comb begin
        spec1 = 1'b1;
        inv1  = 1'b0;
        sval1 = '0;
        if (x_nan | y_nan) begin
            sval1 = QNAN;
            inv1  = (x_nan & ~fx[NF-1]) | (y_nan & ~fy[NF-1]);
        end else if ((x_inf & y_zero) | (y_inf & x_zero)) begin
            sval1 = QNAN;
            inv1  = 1'b1;
        end else if (x_inf | y_inf) begin
            sval1 = {sgn1, {NE{1'b1}}, {NF{1'b0}}};
        end else if (x_zero | y_zero) begin
            sval1 = {sgn1, {(NE+NF){1'b0}}};
        end else begin
            spec1 = 1'b0;
        end
    end

    logic            s1_valid, s1_sign, s1_spec, s1_inv;
    logic [W-1:0]    s1_sval;
    logic [MW-1:0]   s1_mul;
    logic [EW-1:0]   s1_exp;
    logic [1:0]      s1_rm;
    logic [TAGW-1:0] s1_tag;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
        end else if (en) begin
            s1_valid <= r0_valid;
            s1_sign  <= sgn1;
            s1_spec  <= spec1;
            s1_inv   <= inv1;
            s1_sval  <= sval1;
            s1_mul   <= mul1;
            s1_exp   <= esum1;
            s1_rm    <= r0_rm;
            s1_tag   <= r0_tag;
        end
    end

    logic          hi, guard, sticky, inc;
    logic [MW-2:0] norm;
    logic [NF-1:0] frac_n;
    logic [NF:0]   rnd;
    logic [EW-1:0] exp_r;

    assign hi     = s1_mul[MW-1];
    assign norm   = hi ? s1_mul[MW-2:0] : {s1_mul[MW-3:0], 1'b0};
    assign frac_n = norm[MW-2 -: NF];
    assign guard  = norm[NF];
    assign sticky = |norm[NF-1:0];

    always_comb begin
        inc = 1'b0;
        case (s1_rm)
            MODE_RZ:  inc = 1'b0;
            MODE_RNE: inc = guard & (sticky | frac_n[0]);
            MODE_RM:  inc = s1_sign & (guard | sticky);
            MODE_RP:  inc = ~s1_sign & (guard | sticky);
            default:  inc = 1'b0;
        endcase
    end

    // A rounding carry leaves the fraction at zero and bumps the exponent.
    assign rnd   = {1'b0, frac_n} + {{NF{1'b0}}, inc};
    assign exp_r = s1_exp + {{(EW-1){1'b0}}, hi} + {{(EW-1){1'b0}}, rnd[NF]};

    logic            s2_valid, s2_sign, s2_spec, s2_inv, s2_inexact;
    logic [W-1:0]    s2_sval;
    logic [NF-1:0]   s2_frac;
    logic [EW-1:0]   s2_exp;
    logic [1:0]      s2_rm;
    logic [TAGW-1:0] s2_tag;

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid <= 1'b0;
        end else if (en) begin
            s2_valid   <= s1_valid;
            s2_sign    <= s1_sign;
            s2_spec    <= s1_spec;
            s2_inv     <= s1_inv;
            s2_sval    <= s1_sval;
            s2_frac    <= rnd[NF-1:0];
            s2_exp     <= exp_r;
            s2_inexact <= guard | sticky;
            s2_rm      <= s1_rm;
            s2_tag     <= s1_tag;
        end
    end

    logic         to_inf;
    logic [W-1:0] res3;
    logic [3:0]   flg3;

    assign to_inf = (s2_rm == MODE_RNE) | ((s2_rm == MODE_RP) & ~s2_sign)
                  | ((s2_rm == MODE_RM) & s2_sign);

    always_comb begin
        res3 = '0;
        flg3 = '0;
        if (s2_spec) begin
            res3 = s2_sval;
            flg3 = {s2_inv, 3'b000};
        end else if ($signed(s2_exp) >= EMAX) begin
            flg3 = 4'b0101;
            res3 = to_inf ? {s2_sign, {NE{1'b1}}, {NF{1'b0}}}
                          : {s2_sign, {(NE-1){1'b1}}, 1'b0, {NF{1'b1}}};
        end else if (s2_exp[EW-1] || (s2_exp == '0)) begin
            flg3 = 4'b0011;
            res3 = {s2_sign, {(NE+NF){1'b0}}};
        end else begin
            flg3 = {3'b000, s2_inexact};
            res3 = {s2_sign, s2_exp[NE-1:0], s2_frac};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            product   <= '0;
            flags     <= '0;
            out_tag   <= '0;
        end else if (en) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                product <= res3;
                flags   <= flg3;
                out_tag <= s2_tag;
            end
        end
    end
endmodule

// File: tb/tb_fmul_pipe.sv
// tb/tb_fmul_pipe.sv - randomized scoreboard bench for fmul_pipe (half precision)
module tb_fmul_pipe;
    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, negp, out_valid, out_ready;
    logic [15:0] x, y, product;
    logic [1:0]  roundmode;
    logic [3:0]  in_tag, flags, out_tag;

    fmul_pipe #(.NE(5), .NF(10), .TAGW(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .negp(negp), .roundmode(roundmode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .product(product),
        .flags(flags), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] res;
        logic [3:0]  tag;
        int          edge_no;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0, n_err = 0, cyc = 0, n_pop = 0;
    bit   strict_lat = 1'b1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Reference: exact integer product, explicit remainder-based rounding.
    function automatic logic [19:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                            input logic ng, input logic [1:0] rm);
        logic s;
        int ea, eb, fa, fb, p, sh, q, rem, half, e;
        bit an, bn, ai, bi, az, bz, up, exact;
        s  = a[15] ^ b[15] ^ ng;
        ea = a[14:10]; eb = b[14:10]; fa = a[9:0]; fb = b[9:0];
        an = (ea == 31) && (fa != 0); bn = (eb == 31) && (fb != 0);
        ai = (ea == 31) && (fa == 0); bi = (eb == 31) && (fb == 0);
        az = (ea == 0);               bz = (eb == 0);
        if (an || bn) return {(an && fa < 512) || (bn && fb < 512), 3'b000, 16'h7E00};
        if ((ai && bz) || (bi && az)) return {4'b1000, 16'h7E00};
        if (ai || bi) return {4'b0000, s, 5'h1F, 10'h000};
        if (az || bz) return {4'b0000, s, 15'h0000};
        p     = (1024 + fa) * (1024 + fb);
        sh    = (p >= (1 << 21)) ? 11 : 10;
        q     = p >> sh;
        rem   = p - (q << sh);
        half  = 1 << (sh - 1);
        exact = (rem == 0);
        case (rm)
            2'd0:    up = 1'b0;
            2'd1:    up = (rem > half) || ((rem == half) && (q % 2 == 1));
            2'd2:    up = s && !exact;
            default: up = !s && !exact;
        endcase
        q = q + up;
        e = ea + eb - 15 + (sh - 10);
        if (q == 2048) begin q = 1024; e++; end
        if (e >= 31) begin
            if (rm == 2'd1 || (rm == 2'd3 && !s) || (rm == 2'd2 && s))
                return {4'b0101, s, 5'h1F, 10'h000};
            return {4'b0101, s, 5'h1E, 10'h3FF};
        end
        if (e <= 0) return {4'b0011, s, 15'h0000};
        return {3'b000, !exact, s, e[4:0], q[9:0]};
    endfunction

    task automatic cycle(input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic ng, input logic [1:0] rm, input logic [3:0] t,
                         input logic ordy, input logic use_want, input logic [19:0] want,
                         output logic acc);
        exp_t        e;
        logic        stall;
        logic [23:0] snap;
        in_valid = v; x = a; y = b; negp = ng; roundmode = rm; in_tag = t; out_ready = ordy;
        #1;
        chk("in_ready", in_ready, !(out_valid && !out_ready));
        acc = in_valid && in_ready;
        if (acc) begin
            e.res     = use_want ? want : ref_mul(a, b, ng, rm);
            e.tag     = t;
            e.edge_no = cyc + 1;
            sb.push_back(e);
        end
        if (out_valid && out_ready) begin
            n_pop++;
            if (sb.size() == 0) chk("spurious_result", 1, 0);
            else begin
                e = sb.pop_front();
                chk("product", product, e.res[15:0]);
                chk("flags", flags, e.res[19:16]);
                chk("out_tag", out_tag, e.tag);
                if (strict_lat) chk("latency", cyc - e.edge_no, 3);
            end
        end
        stall = out_valid && !out_ready;
        snap  = {product, flags, out_tag};
        @(posedge clk);
        cyc++;
        #1;
        if (stall) begin
            chk("held_valid", out_valid, 1);
            chk("held_data", {product, flags, out_tag}, snap);
        end
    endtask

    task automatic drain();
        logic a;
        int   i;
        i = 0;
        while (sb.size() != 0 && i < 40) begin
            cycle(1'b0, 16'h0, 16'h0, 1'b0, 2'd1, 4'h0, 1'b1, 1'b0, 20'h0, a);
            i++;
        end
        chk("drain_empty", sb.size(), 0);
        sb.delete();
        repeat (6) cycle(1'b0, 16'h0, 16'h0, 1'b0, 2'd1, 4'h0, 1'b1, 1'b0, 20'h0, a);
    endtask

    // {roundmode, negp, x, y, flags, product}
    logic [54:0] dir [17] = '{
        {2'd1, 1'b0, 16'h3C00, 16'h4000, 4'h0, 16'h4000},
        {2'd1, 1'b0, 16'h3E00, 16'h3E00, 4'h0, 16'h4080},
        {2'd1, 1'b1, 16'h3C00, 16'h4000, 4'h0, 16'hC000},
        {2'd0, 1'b0, 16'h3C01, 16'h3C01, 4'h1, 16'h3C02},
        {2'd3, 1'b0, 16'h3C01, 16'h3C01, 4'h1, 16'h3C03},
        {2'd1, 1'b0, 16'h3C01, 16'h3C01, 4'h1, 16'h3C02},
        {2'd2, 1'b0, 16'h3C01, 16'h3C01, 4'h1, 16'h3C02},
        {2'd1, 1'b0, 16'h7BFF, 16'h7BFF, 4'h5, 16'h7C00},
        {2'd0, 1'b0, 16'h7BFF, 16'h7BFF, 4'h5, 16'h7BFF},
        {2'd2, 1'b0, 16'hFBFF, 16'h7BFF, 4'h5, 16'hFC00},
        {2'd3, 1'b0, 16'hFBFF, 16'h7BFF, 4'h5, 16'hFBFF},
        {2'd1, 1'b0, 16'h0400, 16'h3800, 4'h3, 16'h0000},
        {2'd1, 1'b0, 16'h7C00, 16'h0000, 4'h8, 16'h7E00},
        {2'd1, 1'b0, 16'h7D00, 16'h3C00, 4'h8, 16'h7E00},
        {2'd1, 1'b0, 16'h7E00, 16'h3C00, 4'h0, 16'h7E00},
        {2'd1, 1'b0, 16'h0001, 16'h4000, 4'h0, 16'h0000},
        {2'd1, 1'b1, 16'hFC00, 16'h4000, 4'h0, 16'h7C00}
    };

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        acc;
        logic [31:0] r;
        logic [54:0] d;
        int          k, p0;
        reset = 1'b1; in_valid = 1'b0; x = '0; y = '0; negp = 1'b0;
        roundmode = 2'd1; in_tag = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_product", product, 0);
        chk("rst_flags", flags, 0);
        chk("rst_out_tag", out_tag, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);

        // Directed vectors streamed back-to-back.
        for (int i = 0; i < 17; i++) begin
            d = dir[i];
            cycle(1'b1, d[51:36], d[35:20], d[52], d[54:53], 4'(i), 1'b1, 1'b1, d[19:0], acc);
        end
        drain();

        // Random operands with input bubbles, no backpressure.
        for (int i = 0; i < 250; i++) begin
            r = $urandom;
            cycle($urandom_range(0, 3) != 0, r[15:0], r[31:16], 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), 4'(i), 1'b1, 1'b0, 20'h0, acc);
        end
        drain();

        // Backpressure: six tagged ops, output blocked for five cycles.
        strict_lat = 1'b0;
        p0 = n_pop;
        k  = 0;
        for (int i = 0; i < 30; i++) begin
            r = $urandom;
            cycle(k < 6, r[15:0], r[31:16], 1'b0, 2'd1, 4'(k), !(i >= 4 && i < 9),
                  1'b0, 20'h0, acc);
            if (acc) k++;
        end
        drain();
        chk("bp_accepted", k, 6);
        chk("bp_results", n_pop - p0, 6);

        // Random operands with random backpressure.
        for (int i = 0; i < 250; i++) begin
            r = $urandom;
            cycle($urandom_range(0, 1) != 0, r[15:0], r[31:16], 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), 4'(i), $urandom_range(0, 2) != 0, 1'b0, 20'h0, acc);
        end
        drain();

        // Reset with two ops in flight.
        strict_lat = 1'b1;
        cycle(1'b1, 16'h3C00, 16'h4000, 1'b0, 2'd1, 4'hA, 1'b1, 1'b0, 20'h0, acc);
        cycle(1'b1, 16'h4000, 16'h4000, 1'b0, 2'd1, 4'hB, 1'b1, 1'b0, 20'h0, acc);
        reset = 1'b1;
        cycle(1'b0, 16'h0, 16'h0, 1'b0, 2'd1, 4'h0, 1'b1, 1'b0, 20'h0, acc);
        reset = 1'b0;
        sb.delete();
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_product", product, 0);
        chk("mid_rst_flags", flags, 0);
        chk("mid_rst_out_tag", out_tag, 0);
        cycle(1'b1, 16'h3E00, 16'h3E00, 1'b0, 2'd1, 4'h5, 1'b1, 1'b1, 20'h04080, acc);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
